// File: rtl/cbox16_cu_pkg.sv
// rtl/cbox16_cu_pkg.sv - CBox16 control unit opcodes, field positions, states and control bundle
package cbox16_cu_pkg;

  localparam int DATA_W = 16;
  localparam int OPC_W  = 4;
  localparam int REG_W  = 3;

  localparam int OPC_LSB = 12;
  localparam int RD_LSB  = 9;
  localparam int RS1_LSB = 6;
  localparam int RS2_LSB = 3;
  localparam int IMM_LSB = 0;

  localparam logic [OPC_W-1:0] OPC_NOP   = 4'h0;
  localparam logic [OPC_W-1:0] OPC_ADD   = 4'h1;
  localparam logic [OPC_W-1:0] OPC_SUB   = 4'h2;
  localparam logic [OPC_W-1:0] OPC_AND   = 4'h3;
  localparam logic [OPC_W-1:0] OPC_OR    = 4'h4;
  localparam logic [OPC_W-1:0] OPC_LDI   = 4'h5;
  localparam logic [OPC_W-1:0] OPC_LDR   = 4'h6;
  localparam logic [OPC_W-1:0] OPC_STR   = 4'h7;
  localparam logic [OPC_W-1:0] OPC_B     = 4'h8;
  localparam logic [OPC_W-1:0] OPC_BZ    = 4'h9;
  localparam logic [OPC_W-1:0] OPC_BN    = 4'hA;
  localparam logic [OPC_W-1:0] OPC_BC    = 4'hB;
  localparam logic [OPC_W-1:0] OPC_BV    = 4'hC;
  localparam logic [OPC_W-1:0] OPC_ILL_D = 4'hD;
  localparam logic [OPC_W-1:0] OPC_ILL_E = 4'hE;
  localparam logic [OPC_W-1:0] OPC_HALT  = 4'hF;

  localparam logic [1:0] DMUX_ALU = 2'd0;
  localparam logic [1:0] DMUX_IN  = 2'd1;
  localparam logic [1:0] DMUX_MEM = 2'd2;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_HALT   = 3'd4
  } state_e;

  typedef struct packed {
    logic z;
    logic n;
    logic c;
    logic v;
  } flags_t;

  typedef struct packed {
    logic [REG_W-1:0]  rs1;
    logic [REG_W-1:0]  rs2;
    logic [REG_W-1:0]  ws;
    logic              we;
    logic              str;
    logic              ldr;
    logic [DATA_W-1:0] imm;
    logic [1:0]        aluop;
    logic [1:0]        dmux;
    logic              alu;
    logic              halt;
    logic              illegal;
  } ctrl_t;

endpackage

// File: rtl/cbox16_cu_decoder.sv
// rtl/cbox16_cu_decoder.sv - combinational decode of IR and latched flags into a control bundle
module cbox16_cu_decoder
  import cbox16_cu_pkg::*;
#(
  parameter int PC_W  = 8,
  parameter int IMM_W = 9
) (
  input  logic [DATA_W-1:0] ir_i,
  input  flags_t            flags_i,
  output ctrl_t             ctrl_o,
  output logic              br_taken_o,
  output logic [PC_W-1:0]   target_o
);

  logic [OPC_W-1:0] opc;

  assign opc      = ir_i[OPC_LSB +: OPC_W];
  assign target_o = PC_W'(ir_i[IMM_LSB +: IMM_W]);

  always_comb begin
    ctrl_o     = '0;
    br_taken_o = 1'b0;
    ctrl_o.rs1 = ir_i[RS1_LSB +: REG_W];
    ctrl_o.rs2 = ir_i[RS2_LSB +: REG_W];
    ctrl_o.ws  = ir_i[RD_LSB +: REG_W];
    ctrl_o.imm = DATA_W'($signed(ir_i[IMM_LSB +: IMM_W]));
    case (opc)
      OPC_NOP: ;
      OPC_ADD, OPC_SUB, OPC_AND, OPC_OR: begin
        ctrl_o.aluop = 2'(opc - OPC_ADD);
        ctrl_o.dmux  = DMUX_ALU;
        ctrl_o.we    = 1'b1;
        ctrl_o.alu   = 1'b1;
      end
      OPC_LDI: begin
        ctrl_o.dmux = DMUX_IN;
        ctrl_o.we   = 1'b1;
      end
      OPC_LDR: begin
        ctrl_o.dmux = DMUX_MEM;
        ctrl_o.ldr  = 1'b1;
        ctrl_o.we   = 1'b1;
      end
      OPC_STR:  ctrl_o.str = 1'b1;
      OPC_B:    br_taken_o = 1'b1;
      OPC_BZ:   br_taken_o = flags_i.z;
      OPC_BN:   br_taken_o = flags_i.n;
      OPC_BC:   br_taken_o = flags_i.c;
      OPC_BV:   br_taken_o = flags_i.v;
      OPC_ILL_D, OPC_ILL_E: ctrl_o.illegal = 1'b1;
      OPC_HALT: ctrl_o.halt = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: rtl/cbox16_control_unit.sv
// rtl/cbox16_control_unit.sv - CBox16 sequencer: fetch over req/ack, decode, one-cycle EXEC strobes
// Optional STEP input gating each fetch when CBOX16_CU_SINGLE_STEP_EN is defined.
module cbox16_control_unit
  import cbox16_cu_pkg::*;
#(
  parameter int PC_W  = 8,
  parameter int IMM_W = 9
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              RUN,
`ifdef CBOX16_CU_SINGLE_STEP_EN
  input  logic              STEP,
`endif
  output logic              IMEM_REQ,
  output logic [PC_W-1:0]   IMEM_ADDR,
  input  logic              IMEM_ACK,
  input  logic [DATA_W-1:0] IMEM_DATA,
  output logic [REG_W-1:0]  RS1,
  output logic [REG_W-1:0]  RS2,
  output logic [REG_W-1:0]  WS,
  output logic              WE,
  output logic              STR,
  output logic              LDR,
  output logic [DATA_W-1:0] IN,
  output logic [1:0]        ALUOP,
  output logic [1:0]        DMUX,
  input  logic              Z,
  input  logic              N,
  input  logic              C,
  input  logic              V,
  output logic              HALTED,
  output logic              ILLEGAL
);

  state_e            state_q;
  logic [PC_W-1:0]   pc_q;
  logic [DATA_W-1:0] ir_q;
  flags_t            flags_q;
  ctrl_t             ctrl_q;
  logic              br_taken_q;
  logic              req_q;
  logic              halted_q;
  logic              illegal_q;

  ctrl_t             ctrl_d;
  logic              br_taken_d;
  logic [PC_W-1:0]   target_d;
  logic              step_go;

  // With single-step, FETCH is entered with the request low until STEP is seen.
`ifdef CBOX16_CU_SINGLE_STEP_EN
  localparam logic REQ_ON_FETCH = 1'b0;
  assign step_go = STEP;
`else
  localparam logic REQ_ON_FETCH = 1'b1;
  assign step_go = 1'b1;
`endif

  cbox16_cu_decoder #(
    .PC_W  (PC_W),
    .IMM_W (IMM_W)
  ) u_decoder (
    .ir_i       (ir_q),
    .flags_i    (flags_q),
    .ctrl_o     (ctrl_d),
    .br_taken_o (br_taken_d),
    .target_o   (target_d)
  );

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q    <= ST_IDLE;
      pc_q       <= '0;
      ir_q       <= '0;
      flags_q    <= '0;
      ctrl_q     <= '0;
      br_taken_q <= 1'b0;
      req_q      <= 1'b0;
      halted_q   <= 1'b0;
      illegal_q  <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (RUN) begin
            state_q <= ST_FETCH;
            req_q   <= REQ_ON_FETCH;
          end
        end
        ST_FETCH: begin
          if (!req_q) begin
            req_q <= step_go;
          end else if (IMEM_ACK) begin
            ir_q    <= IMEM_DATA;
            pc_q    <= pc_q + PC_W'(1);
            req_q   <= 1'b0;
            state_q <= ST_DECODE;
          end
        end
        ST_DECODE: begin
          ctrl_q     <= ctrl_d;
          br_taken_q <= br_taken_d;
          state_q    <= ST_EXEC;
        end
        ST_EXEC: begin
          // Strobes last exactly this cycle; selects keep their values afterwards.
          ctrl_q.we  <= 1'b0;
          ctrl_q.str <= 1'b0;
          ctrl_q.ldr <= 1'b0;
          if (ctrl_q.alu) begin
            flags_q <= '{z: Z, n: N, c: C, v: V};
          end
          if (br_taken_q) begin
            pc_q <= target_d;
          end
          if (ctrl_q.halt || ctrl_q.illegal) begin
            state_q   <= ST_HALT;
            halted_q  <= 1'b1;
            illegal_q <= ctrl_q.illegal;
          end else begin
            state_q <= ST_FETCH;
            req_q   <= REQ_ON_FETCH;
          end
        end
        ST_HALT: ;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign IMEM_REQ  = req_q;
  assign IMEM_ADDR = pc_q;
  assign RS1       = ctrl_q.rs1;
  assign RS2       = ctrl_q.rs2;
  assign WS        = ctrl_q.ws;
  assign WE        = ctrl_q.we;
  assign STR       = ctrl_q.str;
  assign LDR       = ctrl_q.ldr;
  assign IN        = ctrl_q.imm;
  assign ALUOP     = ctrl_q.aluop;
  assign DMUX      = ctrl_q.dmux;
  assign HALTED    = halted_q;
  assign ILLEGAL   = illegal_q;

endmodule
